// File: rtl/exu_mul_ctrl_pkg.sv
// exu_mul_ctrl_pkg: shared widths, op encodings and constants for the multiplier controller
package exu_mul_ctrl_pkg;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic RstEnable = 1'b1;
    localparam logic [2:0] INST_MUL = 3'b000;
    localparam logic [2:0] INST_MULH = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU = 3'b011;
    localparam int DATA_W = REG_DATA_WIDTH;
    localparam int ADDR_W = REG_ADDR_WIDTH;
    localparam int TIMEOUT = 40;
    localparam int CNT_W = $clog2(TIMEOUT);
endpackage

// File: rtl/exu_mul_ctrl_if.sv
// exu_mul_ctrl_if: dispatch, multiplier, writeback and hazard signals of the multiplier controller
interface exu_mul_ctrl_if;
    import exu_mul_ctrl_pkg::*;
    logic req_valid_i;
    logic req_ready_o;
    logic [2:0] req_op_i;
    logic [DATA_W-1:0] req_rs1_i;
    logic [DATA_W-1:0] req_rs2_i;
    logic [ADDR_W-1:0] req_waddr_i;
    logic flush_i;
    logic mul_start_o;
    logic [DATA_W-1:0] mul_multiplicand_o;
    logic [DATA_W-1:0] mul_multiplier_o;
    logic [2:0] mul_op_o;
    logic [ADDR_W-1:0] mul_reg_waddr_o;
    logic [DATA_W-1:0] mul_result_i;
    logic mul_ready_i;
    logic mul_busy_i;
    logic [ADDR_W-1:0] mul_reg_waddr_i;
    logic wb_valid_o;
    logic wb_ready_i;
    logic [DATA_W-1:0] wb_data_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic pend_valid_o;
    logic [ADDR_W-1:0] pend_waddr_o;
    logic err_o;
    modport slave (
        input req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_waddr_i, flush_i,
        input mul_result_i, mul_ready_i, mul_busy_i, mul_reg_waddr_i, wb_ready_i,
        output req_ready_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o, mul_op_o,
        output mul_reg_waddr_o, wb_valid_o, wb_data_o, wb_waddr_o, pend_valid_o, pend_waddr_o, err_o
    );
    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_waddr_i, flush_i,
        output mul_result_i, mul_ready_i, mul_busy_i, mul_reg_waddr_i, wb_ready_i,
        input req_ready_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o, mul_op_o,
        input mul_reg_waddr_o, wb_valid_o, wb_data_o, wb_waddr_o, pend_valid_o, pend_waddr_o, err_o
    );
endinterface

// File: rtl/exu_wb_buf.sv
// exu_wb_buf: one-entry valid/ready result register with flush
module exu_wb_buf
    import exu_mul_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          flush_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [AW-1:0] waddr_o
);
    logic valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] waddr_q, waddr_d;

    // entry fills on load, empties on consumer accept or flush; payload only changes on load
    always_comb begin
        valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : valid_q && !ready_i;
        data_d = load_i ? data_i : data_q;
        waddr_d = load_i ? waddr_i : waddr_q;
    end

    // entry registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= 1'b0;
            data_q <= '0;
            waddr_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q <= data_d;
            waddr_q <= waddr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o = data_q;
    assign waddr_o = waddr_q;
endmodule

// File: rtl/exu_mul_ctrl.sv
// exu_mul_ctrl: EX-stage initiator for the multiplier start/busy/ready protocol
module exu_mul_ctrl
    import exu_mul_ctrl_pkg::*;
(
    input logic     clk,
    input logic     rst,
    exu_mul_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic run, timeout, done, wb_load, req_ready, accept;
    logic wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_waddr;

    // next state: ready wins over timeout, flush wins over ready (result dropped, no drain since the pulse is already consumed)
    always_comb begin
        run = state_q == RUN;
        timeout = run && cnt_q == CNT_W'(TIMEOUT - 1);
        done = run && io.mul_ready_i;
        wb_load = done && !io.flush_i;
        req_ready = state_q == IDLE && !io.flush_i && (!wb_valid || io.wb_ready_i);
        accept = io.req_valid_i && req_ready;
        state_d = accept ? RUN
                : run ? (done ? IDLE : (io.flush_i || timeout) ? DRAIN : RUN)
                : state_q == DRAIN ? IDLE : state_q;
        cnt_d = accept ? '0 : run ? cnt_q + CNT_W'(1) : cnt_q;
        op_d = accept ? io.req_op_i : op_q;
        rs1_d = accept ? io.req_rs1_i : rs1_q;
        rs2_d = accept ? io.req_rs2_i : rs2_q;
        waddr_d = accept ? io.req_waddr_i : waddr_q;
    end

    // state, RUN-cycle counter and latched operands
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= IDLE;
            cnt_q <= '0;
            op_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            waddr_q <= waddr_d;
        end
    end

    exu_wb_buf #(.DW(DATA_W), .AW(ADDR_W)) u_wb_buf (
        .clk(clk),
        .rst(rst),
        .load_i(wb_load),
        .data_i(io.mul_result_i),
        .waddr_i(waddr_q),
        .flush_i(io.flush_i),
        .ready_i(io.wb_ready_i),
        .valid_o(wb_valid),
        .data_o(wb_data),
        .waddr_o(wb_waddr)
    );

    assign io.req_ready_o = req_ready;
    assign io.mul_start_o = run && !io.mul_ready_i && !io.flush_i && !timeout;
    assign io.mul_multiplicand_o = rs1_q;
    assign io.mul_multiplier_o = rs2_q;
    assign io.mul_op_o = op_q;
    assign io.mul_reg_waddr_o = waddr_q;
    assign io.wb_valid_o = wb_valid;
    assign io.wb_data_o = wb_data;
    assign io.wb_waddr_o = wb_waddr;
    assign io.pend_valid_o = run || wb_valid;
    assign io.pend_waddr_o = run ? waddr_q : wb_waddr;
    assign io.err_o = run && !io.flush_i && (io.mul_ready_i ? io.mul_reg_waddr_i != waddr_q : timeout);
endmodule

// File: tb/tb_exu_mul_ctrl.sv
// tb_exu_mul_ctrl: randomized scenario bench for exu_mul_ctrl with a nominal-latency multiplier stub
module tb_exu_mul_ctrl;
    import exu_mul_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int starts = 0;
    logic start_prev = 1'b0;
    int scnt = 0;
    logic stub_ready = 1'b0;
    logic hang = 1'b0;
    logic bad = 1'b0;
    logic inj = 1'b0;

    exu_mul_ctrl_if bus();
    exu_mul_ctrl dut (.clk(clk), .rst(rst), .io(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p = op == INST_MUL ? ua * ub : op == INST_MULH ? sa * sb : op == INST_MULHSU ? sa * ub : ua * ub;
        return op == INST_MUL ? p[31:0] : p[63:32];
    endfunction

    // stub: result ready one cycle after start has been held for 34 cycles; restarts if start drops
    always @(posedge clk) begin
        if (rst) begin
            scnt <= 0;
            stub_ready <= 1'b0;
        end else if (stub_ready) begin
            stub_ready <= 1'b0;
            scnt <= 0;
        end else if (bus.mul_start_o && !hang) begin
            if (scnt == 33) begin
                stub_ready <= 1'b1;
                scnt <= 0;
            end else scnt <= scnt + 1;
        end else scnt <= 0;
    end

    // cycle counter and count of start rising edges
    always @(posedge clk) begin
        cyc <= cyc + 1;
        start_prev <= bus.mul_start_o;
        if (bus.mul_start_o && !start_prev) starts <= starts + 1;
    end

    assign bus.mul_ready_i = stub_ready | inj;
    assign bus.mul_result_i = ref_mul(bus.mul_op_o, bus.mul_multiplicand_o, bus.mul_multiplier_o);
    assign bus.mul_reg_waddr_i = bad ? bus.mul_reg_waddr_o + 5'd1 : bus.mul_reg_waddr_o;
    assign bus.mul_busy_i = bus.mul_start_o && !stub_ready;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] w);
        bus.req_valid_i = 1'b1;
        bus.req_op_i = op;
        bus.req_rs1_i = a;
        bus.req_rs2_i = b;
        bus.req_waddr_i = w;
        #1;
        for (int i = 0; i < 100 && !bus.req_ready_o; i++) step();
        checks++;
        if (bus.req_ready_o !== 1'b1) $display("FAIL issue_accept got req_ready=%b exp 1", bus.req_ready_o);
        else passes++;
        step();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_wb();
        for (int i = 0; i < 80 && !bus.wb_valid_o; i++) step();
        checks++;
        if (bus.wb_valid_o !== 1'b1) $display("FAIL wait_wb got wb_valid=%b exp 1", bus.wb_valid_o);
        else passes++;
    endtask

    task automatic wait_mul_ready();
        for (int i = 0; i < 80 && !bus.mul_ready_i; i++) step();
        checks++;
        if (bus.mul_ready_i !== 1'b1) $display("FAIL wait_mul_ready got %b exp 1", bus.mul_ready_i);
        else passes++;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] w, input logic [31:0] exp);
        int s0;
        s0 = starts;
        issue(op, a, b, w);
        wait_wb();
        checks++;
        if (bus.wb_data_o !== exp) $display("FAIL op_data op=%0d got %h exp %h", op, bus.wb_data_o, exp);
        else passes++;
        checks++;
        if (bus.wb_waddr_o !== w) $display("FAIL op_waddr got %0d exp %0d", bus.wb_waddr_o, w);
        else passes++;
        step();
        checks++;
        if (bus.wb_valid_o !== 1'b0) $display("FAIL op_wb_clear got %b exp 0", bus.wb_valid_o);
        else passes++;
        checks++;
        if (starts - s0 !== 1) $display("FAIL op_starts got %0d exp 1", starts - s0);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if ({bus.mul_start_o, bus.wb_valid_o, bus.pend_valid_o, bus.err_o} !== 4'b0)
            $display("FAIL reset_ctrl got %b exp 0000", {bus.mul_start_o, bus.wb_valid_o, bus.pend_valid_o, bus.err_o});
        else passes++;
        checks++;
        if ({bus.mul_multiplicand_o, bus.mul_multiplier_o, bus.mul_op_o, bus.mul_reg_waddr_o,
             bus.wb_data_o, bus.wb_waddr_o, bus.pend_waddr_o} !== '0)
            $display("FAIL reset_data got %h %h %h %h %h exp 0", bus.mul_multiplicand_o, bus.mul_multiplier_o,
                     bus.mul_op_o, bus.wb_data_o, bus.wb_waddr_o);
        else passes++;
        rst = 1'b0;
        step();
        checks++;
        if (bus.req_ready_o !== 1'b1) $display("FAIL reset_idle_ready got %b exp 1", bus.req_ready_o);
        else passes++;
    endtask

    task automatic test_timing();
        int s0;
        s0 = starts;
        issue(INST_MUL, 32'd7, 32'hFFFFFFFD, 5'd5);
        for (int k = 1; k <= 37; k++) begin
            checks++;
            if (bus.mul_start_o !== (k <= 34)) $display("FAIL timing_start k=%0d got %b exp %b", k, bus.mul_start_o, k <= 34);
            else passes++;
            checks++;
            if (bus.wb_valid_o !== (k == 36)) $display("FAIL timing_wb_valid k=%0d got %b exp %b", k, bus.wb_valid_o, k == 36);
            else passes++;
            checks++;
            if (bus.pend_valid_o !== (k <= 36)) $display("FAIL timing_pend k=%0d got %b exp %b", k, bus.pend_valid_o, k <= 36);
            else passes++;
            if (k == 36) begin
                checks++;
                if (bus.wb_data_o !== 32'hFFFFFFEB) $display("FAIL timing_data got %h exp ffffffeb", bus.wb_data_o);
                else passes++;
                checks++;
                if (bus.wb_waddr_o !== 5'd5) $display("FAIL timing_waddr got %0d exp 5", bus.wb_waddr_o);
                else passes++;
            end
            step();
        end
        checks++;
        if (starts - s0 !== 1) $display("FAIL timing_restart got %0d starts exp 1", starts - s0);
        else passes++;
    endtask

    task automatic test_products();
        logic [2:0] op;
        logic [31:0] a, b;
        logic [4:0] w;
        run_op(INST_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE);
        run_op(INST_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd2, 32'hFFFFFFFF);
        run_op(INST_MULH, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000);
        run_op(INST_MUL, 32'd3, 32'd5, 5'd0, 32'd15);
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            w = 5'($urandom_range(0, 31));
            run_op(op, a, b, w, ref_mul(op, a, b));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        bus.wb_ready_i = 1'b0;
        issue(INST_MUL, a1, b1, 5'd9);
        wait_wb();
        bus.req_valid_i = 1'b1;
        bus.req_op_i = INST_MULHU;
        bus.req_rs1_i = a2;
        bus.req_rs2_i = b2;
        bus.req_waddr_i = 5'd12;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== ref_mul(INST_MUL, a1, b1) || bus.wb_waddr_o !== 5'd9)
                $display("FAIL stall_hold i=%0d got v=%b d=%h w=%0d exp v=1 d=%h w=9", i, bus.wb_valid_o,
                         bus.wb_data_o, bus.wb_waddr_o, ref_mul(INST_MUL, a1, b1));
            else passes++;
            checks++;
            if (bus.req_ready_o !== 1'b0) $display("FAIL stall_req_ready i=%0d got %b exp 0", i, bus.req_ready_o);
            else passes++;
            step();
        end
        bus.wb_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1) $display("FAIL stall_release_accept got %b exp 1", bus.req_ready_o);
        else passes++;
        step();
        bus.req_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.mul_start_o !== 1'b1 || bus.mul_multiplicand_o !== a2 || bus.mul_reg_waddr_o !== 5'd12)
            $display("FAIL b2b_second_start got v=%b s=%b a=%h w=%0d exp v=0 s=1 a=%h w=12", bus.wb_valid_o,
                     bus.mul_start_o, bus.mul_multiplicand_o, bus.mul_reg_waddr_o, a2);
        else passes++;
        wait_wb();
        checks++;
        if (bus.wb_data_o !== ref_mul(INST_MULHU, a2, b2) || bus.wb_waddr_o !== 5'd12)
            $display("FAIL b2b_second_result got %h w=%0d exp %h w=12", bus.wb_data_o, bus.wb_waddr_o, ref_mul(INST_MULHU, a2, b2));
        else passes++;
        step();
    endtask

    task automatic test_flush();
        issue(INST_MUL, $urandom, $urandom, 5'd3);
        repeat (9) step();
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if (bus.mul_start_o !== 1'b0 || bus.req_ready_o !== 1'b0)
            $display("FAIL flush_cycle got start=%b req_ready=%b exp 0 0", bus.mul_start_o, bus.req_ready_o);
        else passes++;
        step();
        bus.flush_i = 1'b0;
        inj = 1'b1;
        #1;
        checks++;
        if ({bus.mul_start_o, bus.req_ready_o, bus.wb_valid_o, bus.err_o, bus.pend_valid_o} !== 5'b0)
            $display("FAIL flush_drain got s=%b rr=%b v=%b e=%b p=%b exp all 0", bus.mul_start_o, bus.req_ready_o,
                     bus.wb_valid_o, bus.err_o, bus.pend_valid_o);
        else passes++;
        step();
        inj = 1'b0;
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1 || bus.wb_valid_o !== 1'b0)
            $display("FAIL flush_after_drain got rr=%b v=%b exp 1 0", bus.req_ready_o, bus.wb_valid_o);
        else passes++;
        step();
        checks++;
        if (bus.wb_valid_o !== 1'b0) $display("FAIL flush_stale_wb got %b exp 0", bus.wb_valid_o);
        else passes++;
        issue(INST_MUL, $urandom, $urandom, 5'd4);
        wait_mul_ready();
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if (bus.mul_start_o !== 1'b0 || bus.err_o !== 1'b0)
            $display("FAIL flush_ready_cycle got s=%b e=%b exp 0 0", bus.mul_start_o, bus.err_o);
        else passes++;
        step();
        bus.flush_i = 1'b0;
        #1;
        checks++;
        if (bus.wb_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.pend_valid_o !== 1'b0)
            $display("FAIL flush_ready_idle got v=%b rr=%b p=%b exp 0 1 0", bus.wb_valid_o, bus.req_ready_o, bus.pend_valid_o);
        else passes++;
        step();
    endtask

    task automatic test_timeout();
        hang = 1'b1;
        issue(INST_MULH, $urandom, $urandom, 5'd7);
        for (int k = 1; k <= 42; k++) begin
            checks++;
            if (bus.err_o !== (k == 40) || bus.mul_start_o !== (k < 40) || bus.wb_valid_o !== 1'b0)
                $display("FAIL timeout k=%0d got e=%b s=%b v=%b exp e=%b s=%b v=0", k, bus.err_o, bus.mul_start_o,
                         bus.wb_valid_o, k == 40, k < 40);
            else passes++;
            if (k >= 41) begin
                checks++;
                if (bus.req_ready_o !== (k == 42)) $display("FAIL timeout_ready k=%0d got %b exp %b", k, bus.req_ready_o, k == 42);
                else passes++;
            end
            step();
        end
        hang = 1'b0;
    endtask

    task automatic test_bad_waddr();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        bad = 1'b1;
        issue(INST_MUL, a, b, 5'd5);
        checks++;
        if (bus.err_o !== 1'b0) $display("FAIL badw_early_err got %b exp 0", bus.err_o);
        else passes++;
        wait_mul_ready();
        checks++;
        if (bus.err_o !== 1'b1) $display("FAIL badw_err got %b exp 1", bus.err_o);
        else passes++;
        step();
        bad = 1'b0;
        checks++;
        if (bus.wb_valid_o !== 1'b1 || bus.wb_waddr_o !== 5'd5 || bus.wb_data_o !== ref_mul(INST_MUL, a, b) || bus.err_o !== 1'b0)
            $display("FAIL badw_deliver got v=%b w=%0d d=%h e=%b exp 1 5 %h 0", bus.wb_valid_o, bus.wb_waddr_o,
                     bus.wb_data_o, bus.err_o, ref_mul(INST_MUL, a, b));
        else passes++;
        step();
    endtask

    task automatic test_reset_midop();
        logic [31:0] a, b;
        issue(INST_MULHSU, $urandom, $urandom, 5'd11);
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.mul_start_o, bus.wb_valid_o, bus.pend_valid_o, bus.err_o} !== 4'b0)
            $display("FAIL midrst_ctrl got %b exp 0000", {bus.mul_start_o, bus.wb_valid_o, bus.pend_valid_o, bus.err_o});
        else passes++;
        checks++;
        if ({bus.mul_multiplicand_o, bus.mul_multiplier_o, bus.mul_op_o, bus.mul_reg_waddr_o, bus.pend_waddr_o} !== '0)
            $display("FAIL midrst_data got %h %h %h exp 0", bus.mul_multiplicand_o, bus.mul_multiplier_o, bus.mul_op_o);
        else passes++;
        checks++;
        if (bus.req_ready_o !== 1'b1) $display("FAIL midrst_ready got %b exp 1", bus.req_ready_o);
        else passes++;
        a = $urandom;
        b = $urandom;
        run_op(INST_MULHSU, a, b, 5'd11, ref_mul(INST_MULHSU, a, b));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_op_i = '0;
        bus.req_rs1_i = '0;
        bus.req_rs2_i = '0;
        bus.req_waddr_i = '0;
        bus.flush_i = 1'b0;
        bus.wb_ready_i = 1'b1;
        test_reset();
        test_timing();
        test_products();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_bad_waddr();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
